// File: rtl/msi_pkg.sv
// msi_pkg
//   Shared definitions for the MSI snooping bus: bus command encoding,
//   memory-responder FSM states and the default bus widths that the cache
//   controllers also use.
//   Contents:
//     MSI_ADDR_W / MSI_DATA_W  default address/data widths of the bus
//     bus_cmd_e                BusRd, BusRdX, BusUpgr, Flush (writeback)
//     mem_state_e              IDLE, WAIT, RESP
package msi_pkg;

  localparam int MSI_ADDR_W = 8;
  localparam int MSI_DATA_W = 8;

  typedef enum logic [1:0] {
    BUS_RD    = 2'd0,
    BUS_RDX   = 2'd1,
    BUS_UPGR  = 2'd2,
    BUS_FLUSH = 2'd3
  } bus_cmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_e;

endpackage

// File: rtl/msi_mem_array.sv
// msi_mem_array
//   Backing store of the shared memory: DEPTH x DATA_W words, one
//   synchronous write port and one combinational read port. Contents are
//   never reset.
//   Ports:
//     clk    in   system clock, rising edge
//     we     in   write enable
//     waddr  in   write address
//     wdata  in   write data
//     raddr  in   read address
//     rdata  out  mem[raddr], combinational
module msi_mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/msi_mem_responder.sv
// msi_mem_responder
//   Shared-memory end of the MSI snooping bus. Serves BusRd, BusRdX,
//   BusUpgr and Flush one at a time, merges owner interventions (a snooped
//   M copy flushed in the accept cycle) into memory and the response, and
//   returns a single-cycle bus_ready pulse per accepted request.
//   Optional feature: define MEM_STATS_EN to add saturating statistics
//   counters stat_rd (accepted Rd/RdX) and stat_wb (Flush + interventions).
//   Ports:
//     clk         in   system clock, rising edge
//     reset       in   asynchronous active-low reset
//     bus_req     in   single-cycle request strobe
//     bus_cmd     in   bus command (bus_cmd_e encoding)
//     bus_src     in   requesting core id
//     bus_addr    in   line address
//     bus_wdata   in   writeback data (Flush)
//     snoop_hit   in   other cache flushes its M copy this cycle
//     snoop_data  in   owner's data, valid with snoop_hit
//     stat_rd     out  (MEM_STATS_EN) accepted Rd/RdX count
//     stat_wb     out  (MEM_STATS_EN) Flush + intervention count
//     bus_ready   out  one-cycle response pulse
//     bus_rdata   out  line data while bus_ready (Rd/RdX), else 0
//     bus_rsrc    out  requester id of the response
//     bus_busy    out  high whenever the FSM is not IDLE
module msi_mem_responder
  import msi_pkg::*;
#(
  parameter int ADDR_W = MSI_ADDR_W,
  parameter int DATA_W = MSI_DATA_W,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_req,
  input  logic [1:0]        bus_cmd,
  input  logic              bus_src,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  input  logic              snoop_hit,
  input  logic [DATA_W-1:0] snoop_data,
`ifdef MEM_STATS_EN
  output logic [15:0]       stat_rd,
  output logic [15:0]       stat_wb,
`endif
  output logic              bus_ready,
  output logic [DATA_W-1:0] bus_rdata,
  output logic              bus_rsrc,
  output logic              bus_busy
);

  // WAIT lasts RD_LAT cycles: the counter is loaded with RD_LAT-1 and the
  // FSM leaves WAIT on the edge where it reads 0.
  localparam bit         HAS_WAIT = (RD_LAT > 0);
  localparam logic [3:0] LAT_LOAD = HAS_WAIT ? 4'(RD_LAT - 1) : 4'd0;

  mem_state_e        state_reg;
  logic [3:0]        cnt_reg;
  logic [ADDR_W-1:0] addr_reg;

  logic              accept;
  logic              is_read;
  logic              is_flush;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;

  assign accept   = (state_reg == IDLE) && bus_req;
  assign is_read  = (bus_cmd == BUS_RD) || (bus_cmd == BUS_RDX);
  assign is_flush = (bus_cmd == BUS_FLUSH);

  // Writebacks and interventions land in memory at the accept edge, so any
  // later read of the same line sees the new value.
  assign mem_we    = accept && (is_flush || (is_read && snoop_hit));
  assign mem_wdata = is_flush ? bus_wdata : snoop_data;

  // In IDLE the read port looks at the live bus address (needed when
  // RD_LAT=0 answers straight from the accept edge); afterwards it holds
  // the captured line address.
  assign mem_raddr = (state_reg == IDLE) ? bus_addr : addr_reg;

  msi_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (bus_addr),
    .wdata (mem_wdata),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      addr_reg  <= '0;
      bus_ready <= 1'b0;
      bus_rdata <= '0;
      bus_rsrc  <= 1'b0;
      bus_busy  <= 1'b0;
    end else begin
      bus_ready <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus_req) begin
            addr_reg <= bus_addr;
            bus_rsrc <= bus_src;
            bus_busy <= 1'b1;
            if (is_read && !snoop_hit && HAS_WAIT) begin
              state_reg <= WAIT;
              cnt_reg   <= LAT_LOAD;
            end else begin
              state_reg <= RESP;
              bus_ready <= 1'b1;
              if (!is_read) begin
                bus_rdata <= '0;
              end else if (snoop_hit) begin
                bus_rdata <= snoop_data;
              end else begin
                bus_rdata <= mem_rdata;
              end
            end
          end
        end
        WAIT: begin
          if (cnt_reg == 4'd0) begin
            state_reg <= RESP;
            bus_ready <= 1'b1;
            bus_rdata <= mem_rdata;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          state_reg <= IDLE;
          bus_rdata <= '0;
          bus_busy  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          bus_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_STATS_EN
  // Interventions arrive on Rd/RdX, so they bump both counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_rd <= 16'd0;
      stat_wb <= 16'd0;
    end else if (accept) begin
      if (is_read && stat_rd != 16'hFFFF) begin
        stat_rd <= stat_rd + 16'd1;
      end
      if ((is_flush || (is_read && snoop_hit)) && stat_wb != 16'hFFFF) begin
        stat_wb <= stat_wb + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_msi_mem_responder.sv
// tb_msi_mem_responder
//   Directed self-checking bench for msi_mem_responder (RD_LAT=2).
//   Define MEM_STATS_EN to also exercise the statistics counters.
module tb_msi_mem_responder;

  localparam int RD_LAT = 2;
  localparam logic [1:0] C_RD = 2'd0, C_RDX = 2'd1, C_UPGR = 2'd2, C_FLUSH = 2'd3;

  logic       clk;
  logic       reset;
  logic       bus_req;
  logic [1:0] bus_cmd;
  logic       bus_src;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       snoop_hit;
  logic [7:0] snoop_data;
  logic       bus_ready;
  logic [7:0] bus_rdata;
  logic       bus_rsrc;
  logic       bus_busy;
`ifdef MEM_STATS_EN
  logic [15:0] stat_rd;
  logic [15:0] stat_wb;
`endif

  int tests;
  int fails;

  msi_mem_responder #(
    .ADDR_W (8),
    .DATA_W (8),
    .DEPTH  (256),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus_req    (bus_req),
    .bus_cmd    (bus_cmd),
    .bus_src    (bus_src),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .snoop_hit  (snoop_hit),
    .snoop_data (snoop_data),
`ifdef MEM_STATS_EN
    .stat_rd    (stat_rd),
    .stat_wb    (stat_wb),
`endif
    .bus_ready  (bus_ready),
    .bus_rdata  (bus_rdata),
    .bus_rsrc   (bus_rsrc),
    .bus_busy   (bus_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request starting from a negedge, waits (bounded) for the
  // ready pulse and returns its latency in cycles after the accept edge.
  // Ends on the negedge after RESP, with the DUT back in IDLE.
  task automatic do_req(input logic [1:0] cmd, input logic src,
                        input logic [7:0] addr, input logic [7:0] wdata,
                        input logic snp, input logic [7:0] sdata,
                        output int lat, output logic [7:0] rd, output logic rs);
    bit done;
    bus_req    = 1'b1;
    bus_cmd    = cmd;
    bus_src    = src;
    bus_addr   = addr;
    bus_wdata  = wdata;
    snoop_hit  = snp;
    snoop_data = sdata;
    @(posedge clk);
    #1;
    bus_req   = 1'b0;
    snoop_hit = 1'b0;
    lat  = 0;
    rd   = 8'h00;
    rs   = 1'b0;
    done = 1'b0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus_ready) begin
        rd   = bus_rdata;
        rs   = bus_rsrc;
        done = 1'b1;
      end
    end
    @(negedge clk);
    $display("[TB] req cmd=%0d src=%0d addr=%h wdata=%h snoop=%0d/%h -> lat=%0d rdata=%h rsrc=%0d",
             cmd, src, addr, wdata, snp, sdata, lat, rd, rs);
  endtask

  task automatic test_reset();
    int lat;
    logic [7:0] rd;
    logic rs;
    int readies;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({bus_ready, bus_rdata, bus_rsrc, bus_busy} !== 11'd0) begin
      fails++;
      $display("FAIL reset_outputs: got ready=%b rdata=%h rsrc=%b busy=%b, want all 0",
               bus_ready, bus_rdata, bus_rsrc, bus_busy);
    end
    reset = 1'b1;
    @(negedge clk);

    do_req(C_FLUSH, 1'b0, 8'h20, 8'h5A, 1'b0, 8'h00, lat, rd, rs);

    // Start a memory read, then pull reset while it sits in WAIT.
    bus_req = 1'b1; bus_cmd = C_RD; bus_src = 1'b1; bus_addr = 8'h20;
    @(posedge clk);
    #1 bus_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests++;
    if ({bus_ready, bus_rdata, bus_rsrc, bus_busy} !== 11'd0) begin
      fails++;
      $display("FAIL reset_mid_wait: got ready=%b rdata=%h rsrc=%b busy=%b, want all 0",
               bus_ready, bus_rdata, bus_rsrc, bus_busy);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    readies = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus_ready) readies++;
    end
    tests++;
    if (readies !== 0) begin
      fails++;
      $display("FAIL reset_drops_txn: got %0d ready pulses, want 0", readies);
    end
    $display("[TB] reset mid-WAIT: ready pulses after release=%0d", readies);

    do_req(C_RD, 1'b0, 8'h20, 8'h00, 1'b0, 8'h00, lat, rd, rs);
    tests++;
    if (lat !== RD_LAT + 1 || rd !== 8'h5A) begin
      fails++;
      $display("FAIL read_after_reset: got lat=%0d rdata=%h, want lat=%0d rdata=5a",
               lat, rd, RD_LAT + 1);
    end
  endtask

  task automatic test_flush_read();
    int lat;
    logic [7:0] rd;
    logic rs;
    do_req(C_FLUSH, 1'b1, 8'h10, 8'hAB, 1'b0, 8'h00, lat, rd, rs);
    tests++;
    if (lat !== 1 || rd !== 8'h00 || rs !== 1'b1) begin
      fails++;
      $display("FAIL flush_resp: got lat=%0d rdata=%h rsrc=%b, want lat=1 rdata=00 rsrc=1",
               lat, rd, rs);
    end
    do_req(C_RD, 1'b0, 8'h10, 8'h00, 1'b0, 8'h00, lat, rd, rs);
    tests++;
    if (lat !== RD_LAT + 1 || rd !== 8'hAB || rs !== 1'b0) begin
      fails++;
      $display("FAIL flush_then_read: got lat=%0d rdata=%h rsrc=%b, want lat=%0d rdata=ab rsrc=0",
               lat, rd, rs, RD_LAT + 1);
    end
  endtask

  task automatic test_snoop();
    int lat;
    logic [7:0] rd;
    logic rs;
    do_req(C_RDX, 1'b1, 8'h10, 8'h00, 1'b1, 8'hEF, lat, rd, rs);
    tests++;
    if (lat !== 1 || rd !== 8'hEF || rs !== 1'b1) begin
      fails++;
      $display("FAIL snoop_rdx: got lat=%0d rdata=%h rsrc=%b, want lat=1 rdata=ef rsrc=1",
               lat, rd, rs);
    end
    do_req(C_RD, 1'b0, 8'h10, 8'h00, 1'b0, 8'h00, lat, rd, rs);
    tests++;
    if (lat !== RD_LAT + 1 || rd !== 8'hEF) begin
      fails++;
      $display("FAIL snoop_merged: got lat=%0d rdata=%h, want lat=%0d rdata=ef",
               lat, rd, RD_LAT + 1);
    end
  endtask

  task automatic test_upgr();
    int lat;
    logic [7:0] rd;
    logic rs;
    // snoop_hit is asserted but must be ignored for BusUpgr.
    do_req(C_UPGR, 1'b1, 8'h10, 8'h00, 1'b1, 8'h33, lat, rd, rs);
    tests++;
    if (lat !== 1 || rd !== 8'h00 || rs !== 1'b1) begin
      fails++;
      $display("FAIL upgr_resp: got lat=%0d rdata=%h rsrc=%b, want lat=1 rdata=00 rsrc=1",
               lat, rd, rs);
    end
    do_req(C_RD, 1'b0, 8'h10, 8'h00, 1'b0, 8'h00, lat, rd, rs);
    tests++;
    if (rd !== 8'hEF) begin
      fails++;
      $display("FAIL upgr_mem_unchanged: got rdata=%h, want ef", rd);
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    logic [7:0] rd;
    logic rs;
    int readies;
    int busy_errs;
    bus_req = 1'b1; bus_cmd = C_RD; bus_src = 1'b0; bus_addr = 8'h10;
    @(posedge clk);
    #1 bus_req = 1'b0;
    readies   = 0;
    busy_errs = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (bus_ready) readies++;
      if (bus_busy !== (c <= RD_LAT + 1)) busy_errs++;
      if (bus_ready !== (c == RD_LAT + 1)) busy_errs++;
      // Stray Flush while busy: must be neither served nor written.
      if (c == 1) begin
        bus_req = 1'b1; bus_cmd = C_FLUSH; bus_addr = 8'h10; bus_wdata = 8'h00;
      end else if (c == 2) begin
        bus_req = 1'b0;
      end
    end
    $display("[TB] busy ignore: readies=%0d busy/ready timing errors=%0d", readies, busy_errs);
    tests++;
    if (readies !== 1) begin
      fails++;
      $display("FAIL busy_one_ready: got %0d ready pulses, want 1", readies);
    end
    tests++;
    if (busy_errs !== 0) begin
      fails++;
      $display("FAIL busy_timing: got %0d cycle errors, want 0", busy_errs);
    end
    do_req(C_RD, 1'b1, 8'h10, 8'h00, 1'b0, 8'h00, lat, rd, rs);
    tests++;
    if (rd !== 8'hEF || rs !== 1'b1) begin
      fails++;
      $display("FAIL busy_no_write: got rdata=%h rsrc=%b, want rdata=ef rsrc=1", rd, rs);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [7:0] rd;
    logic rs;
    do_req(C_FLUSH, 1'b0, 8'hFF, 8'h12, 1'b0, 8'h00, lat, rd, rs);
    do_req(C_FLUSH, 1'b0, 8'h00, 8'h34, 1'b0, 8'h00, lat, rd, rs);
    do_req(C_RDX, 1'b1, 8'hFF, 8'h00, 1'b0, 8'h00, lat, rd, rs);
    tests++;
    if (lat !== RD_LAT + 1 || rd !== 8'h12 || rs !== 1'b1) begin
      fails++;
      $display("FAIL b2b_top_addr: got lat=%0d rdata=%h rsrc=%b, want lat=%0d rdata=12 rsrc=1",
               lat, rd, rs, RD_LAT + 1);
    end
    do_req(C_RD, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, lat, rd, rs);
    tests++;
    if (rd !== 8'h34) begin
      fails++;
      $display("FAIL b2b_addr_zero: got rdata=%h, want 34", rd);
    end
  endtask

`ifdef MEM_STATS_EN
  task automatic test_stats();
    int lat;
    logic [7:0] rd;
    logic rs;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_req(C_FLUSH, 1'b0, 8'h40, 8'h01, 1'b0, 8'h00, lat, rd, rs);
    do_req(C_FLUSH, 1'b0, 8'h41, 8'h02, 1'b0, 8'h00, lat, rd, rs);
    do_req(C_RD,    1'b0, 8'h40, 8'h00, 1'b0, 8'h00, lat, rd, rs);
    do_req(C_RD,    1'b1, 8'h41, 8'h00, 1'b0, 8'h00, lat, rd, rs);
    do_req(C_RDX,   1'b0, 8'h40, 8'h00, 1'b0, 8'h00, lat, rd, rs);
    do_req(C_RDX,   1'b1, 8'h42, 8'h00, 1'b1, 8'h77, lat, rd, rs);
    do_req(C_UPGR,  1'b0, 8'h40, 8'h00, 1'b1, 8'h55, lat, rd, rs);
    tests++;
    if (stat_rd !== 16'd4 || stat_wb !== 16'd3) begin
      fails++;
      $display("FAIL stats_count: got rd=%0d wb=%0d, want rd=4 wb=3", stat_rd, stat_wb);
    end
    force dut.stat_rd = 16'hFFFE;
    force dut.stat_wb = 16'hFFFE;
    @(negedge clk);
    release dut.stat_rd;
    release dut.stat_wb;
    do_req(C_RD,    1'b0, 8'h40, 8'h00, 1'b1, 8'h01, lat, rd, rs);
    do_req(C_RD,    1'b0, 8'h40, 8'h00, 1'b1, 8'h01, lat, rd, rs);
    tests++;
    if (stat_rd !== 16'hFFFF || stat_wb !== 16'hFFFF) begin
      fails++;
      $display("FAIL stats_saturate: got rd=%h wb=%h, want ffff ffff", stat_rd, stat_wb);
    end
  endtask
`endif

  initial begin
    tests      = 0;
    fails      = 0;
    reset      = 1'b0;
    bus_req    = 1'b0;
    bus_cmd    = 2'd0;
    bus_src    = 1'b0;
    bus_addr   = 8'h00;
    bus_wdata  = 8'h00;
    snoop_hit  = 1'b0;
    snoop_data = 8'h00;
    test_reset();
    test_flush_read();
    test_snoop();
    test_upgr();
    test_busy_ignore();
    test_back_to_back();
`ifdef MEM_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
